// File: rtl/exec_step_controller.sv
// Run-control sequencer that owns the core enable and keeps performance counters.
// en is combinational from state, halted and the breakpoint compare; the counters update one cycle after each enabled cycle, and there is no backpressure.
module exec_step_controller #(
    parameter int CNT_BIT = 32,
    parameter int PC_BIT  = 32
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               cmd_run_i,
    input  logic               cmd_step_i,
    input  logic               cmd_pause_i,
    input  logic               cmd_clr_cnt_i,
    input  logic               bp_en_i,
    input  logic [PC_BIT-1:0]  bp_addr_i,
    input  logic [PC_BIT-1:0]  pc_dbg_i,
    input  logic               halted_i,
    input  logic               jumped_i,
    input  logic               branched_i,
    input  logic               bubble_i,
    output logic               en_o,
    output logic [1:0]         state_o,
    output logic [CNT_BIT-1:0] cnt_cycle_o,
    output logic [CNT_BIT-1:0] cnt_jump_o,
    output logic [CNT_BIT-1:0] cnt_branch_o,
    output logic [CNT_BIT-1:0] cnt_bubble_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2,
        S_HALT = 2'd3
    } state_t;

    localparam logic [CNT_BIT-1:0] CNT_ONE = {{(CNT_BIT-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic               bp_armed_q, bp_armed_d;
    logic               bp_hit;
    logic [CNT_BIT-1:0] cnt_cycle_q,  cnt_cycle_d;
    logic [CNT_BIT-1:0] cnt_jump_q,   cnt_jump_d;
    logic [CNT_BIT-1:0] cnt_branch_q, cnt_branch_d;
    logic [CNT_BIT-1:0] cnt_bubble_q, cnt_bubble_d;

    function automatic logic [CNT_BIT-1:0] sat_inc(input logic [CNT_BIT-1:0] v,
                                                   input logic inc);
        return (inc && !(&v)) ? v + CNT_ONE : v;
    endfunction

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_run_i) begin
                    state_d = S_RUN;
                end else if (cmd_step_i) begin
                    state_d = S_STEP;
                end
            end
            S_RUN: begin
                if (halted_i) begin
                    state_d = S_HALT;
                end else if (cmd_pause_i || bp_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_STEP: begin
                state_d = halted_i ? S_HALT : S_IDLE;
            end
            default: state_d = S_HALT;
        endcase
    end

    always_comb begin
        bp_hit  = bp_en_i && bp_armed_q && (pc_dbg_i == bp_addr_i);
        en_o    = ((state_q == S_RUN) && !bp_hit && !halted_i) ||
                  ((state_q == S_STEP) && !halted_i);
        state_o = state_q;
    end

    // Leaving IDLE disarms so a resume or step sitting on bp_addr executes it;
    // the first fetch away from bp_addr re-arms.
    always_comb begin
        bp_armed_d = bp_armed_q;
        if ((state_q == S_IDLE) && (cmd_run_i || cmd_step_i)) begin
            bp_armed_d = 1'b0;
        end else if (pc_dbg_i != bp_addr_i) begin
            bp_armed_d = 1'b1;
        end
    end

    always_comb begin
        if (cmd_clr_cnt_i) begin
            cnt_cycle_d  = '0;
            cnt_jump_d   = '0;
            cnt_branch_d = '0;
            cnt_bubble_d = '0;
        end else begin
            cnt_cycle_d  = sat_inc(cnt_cycle_q,  en_o);
            cnt_jump_d   = sat_inc(cnt_jump_q,   en_o && jumped_i);
            cnt_branch_d = sat_inc(cnt_branch_q, en_o && branched_i);
            cnt_bubble_d = sat_inc(cnt_bubble_q, en_o && bubble_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            bp_armed_q   <= 1'b1;
            cnt_cycle_q  <= '0;
            cnt_jump_q   <= '0;
            cnt_branch_q <= '0;
            cnt_bubble_q <= '0;
        end else begin
            bp_armed_q   <= bp_armed_d;
            cnt_cycle_q  <= cnt_cycle_d;
            cnt_jump_q   <= cnt_jump_d;
            cnt_branch_q <= cnt_branch_d;
            cnt_bubble_q <= cnt_bubble_d;
        end
    end

    assign cnt_cycle_o  = cnt_cycle_q;
    assign cnt_jump_o   = cnt_jump_q;
    assign cnt_branch_o = cnt_branch_q;
    assign cnt_bubble_o = cnt_bubble_q;

endmodule

// File: tb/tb_exec_step_controller.sv
// Directed bench for exec_step_controller with 4-bit counters so saturation is reachable.
module tb_exec_step_controller;

    localparam int CNT_BIT = 4;
    localparam int PC_BIT  = 32;

    logic               clk = 1'b0;
    logic               rst_n, cmd_run, cmd_step, cmd_pause, cmd_clr_cnt;
    logic               bp_en, halted, jumped, branched, bubble;
    logic [PC_BIT-1:0]  bp_addr, pc_dbg;
    logic               en;
    logic [1:0]         state;
    logic [CNT_BIT-1:0] cnt_cycle, cnt_jump, cnt_branch, cnt_bubble;

    int n_vec = 0;
    int n_err = 0;

    exec_step_controller #(.CNT_BIT(CNT_BIT), .PC_BIT(PC_BIT)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .cmd_run_i     (cmd_run),
        .cmd_step_i    (cmd_step),
        .cmd_pause_i   (cmd_pause),
        .cmd_clr_cnt_i (cmd_clr_cnt),
        .bp_en_i       (bp_en),
        .bp_addr_i     (bp_addr),
        .pc_dbg_i      (pc_dbg),
        .halted_i      (halted),
        .jumped_i      (jumped),
        .branched_i    (branched),
        .bubble_i      (bubble),
        .en_o          (en),
        .state_o       (state),
        .cnt_cycle_o   (cnt_cycle),
        .cnt_jump_o    (cnt_jump),
        .cnt_branch_o  (cnt_branch),
        .cnt_bubble_o  (cnt_bubble)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    // Inputs are driven 1 time unit after the rising edge, outputs sampled 1 unit later.
    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_counters();
        cmd_clr_cnt = 1'b1;
        step_clk();
        cmd_clr_cnt = 1'b0;
    endtask

    initial begin
        int en_cnt;
        logic stopped;
        logic [PC_BIT-1:0] pc, stop_pc;

        rst_n = 1'b0; cmd_run = 1'b1; cmd_step = 1'b0; cmd_pause = 1'b0;
        cmd_clr_cnt = 1'b0; bp_en = 1'b0; bp_addr = '0; pc_dbg = '0;
        halted = 1'b0; jumped = 1'b0; branched = 1'b0; bubble = 1'b0;

        // Reset wins over a held cmd_run
        step_clk();
        step_clk();
        #1;
        check("rst_state", state, 0);
        check("rst_en", en, 0);
        check("rst_cnt_cycle", cnt_cycle, 0);
        check("rst_cnt_jump", cnt_jump, 0);
        check("rst_cnt_branch", cnt_branch, 0);
        check("rst_cnt_bubble", cnt_bubble, 0);
        rst_n = 1'b1; cmd_run = 1'b0;
        step_clk();
        step_clk();
        #1;
        check("idle_en", en, 0);
        check("idle_state", state, 0);

        // Run for ten cycles, pause in the tenth
        cmd_run = 1'b1;
        #1;
        check("run_cmd_en", en, 0);
        step_clk();
        cmd_run = 1'b0;
        en_cnt = 0;
        for (int c = 1; c <= 10; c++) begin
            cmd_pause = (c == 10);
            #1;
            if (en) en_cnt++;
            if (c == 1) check("run_state", state, 1);
            step_clk();
        end
        cmd_pause = 1'b0;
        #1;
        check("pause_en_cycles", en_cnt, 10);
        check("pause_state", state, 0);
        check("pause_en_off", en, 0);
        check("pause_cnt_cycle", cnt_cycle, 10);

        // In IDLE the event inputs are not sampled
        jumped = 1'b1;
        step_clk();
        jumped = 1'b0;
        #1;
        check("idle_no_jump", cnt_jump, 0);

        // Three single steps, a second step pulse during STEP is dropped
        clr_counters();
        en_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            cmd_step = 1'b1;
            #1;
            if (en) en_cnt++;
            step_clk();
            #1;
            if (k == 0) check("step_state", state, 2);
            if (en) en_cnt++;
            step_clk();
            cmd_step = 1'b0;
            for (int j = 0; j < 2; j++) begin
                #1;
                if (en) en_cnt++;
                step_clk();
            end
        end
        #1;
        check("step_en_cycles", en_cnt, 3);
        check("step_cnt_cycle", cnt_cycle, 3);
        check("step_end_state", state, 0);

        // Breakpoint at 0x20 while PC advances by 4 per enabled cycle
        clr_counters();
        bp_en = 1'b1; bp_addr = 32'h20; pc = '0; pc_dbg = '0;
        cmd_run = 1'b1;
        step_clk();
        cmd_run = 1'b0;
        stopped = 1'b0; stop_pc = '0;
        for (int c = 0; c < 30 && !stopped; c++) begin
            #1;
            if (!en) begin
                stopped = 1'b1;
                stop_pc = pc;
            end else begin
                step_clk();
                pc += 4;
                pc_dbg = pc;
            end
        end
        check("bp_stopped", stopped, 1);
        check("bp_stop_pc", stop_pc, 32'h20);
        step_clk();
        #1;
        check("bp_state", state, 0);
        check("bp_cnt_cycle", cnt_cycle, 8);

        // Resume runs through the breakpoint, then stops on the next visit
        cmd_run = 1'b1;
        step_clk();
        cmd_run = 1'b0;
        en_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (en) en_cnt++;
            step_clk();
            if (en) pc += 4;
            pc_dbg = pc;
        end
        check("resume_en_cycles", en_cnt, 6);
        pc_dbg = 32'h20;
        #1;
        check("bp_again_en", en, 0);
        step_clk();
        #1;
        check("bp_again_state", state, 0);
        bp_en = 1'b0;

        // Halt in the seventh RUN cycle
        clr_counters();
        cmd_run = 1'b1;
        step_clk();
        cmd_run = 1'b0;
        en_cnt = 0;
        for (int c = 1; c <= 7; c++) begin
            halted = (c == 7);
            #1;
            if (c < 7 && en) en_cnt++;
            if (c == 7) begin
                check("halt_en_same_cycle", en, 0);
                check("halt_state_same_cycle", state, 1);
            end
            step_clk();
        end
        #1;
        check("halt_run_cycles", en_cnt, 6);
        check("halt_state", state, 3);
        check("halt_cnt_cycle", cnt_cycle, 6);
        cmd_run = 1'b1;
        step_clk();
        cmd_run = 1'b0; cmd_step = 1'b1;
        step_clk();
        cmd_step = 1'b0; halted = 1'b0;
        #1;
        check("halt_sticky_state", state, 3);
        check("halt_sticky_en", en, 0);
        clr_counters();
        #1;
        check("halt_clr_cnt", cnt_cycle, 0);
        rst_n = 1'b0;
        step_clk();
        rst_n = 1'b1;
        #1;
        check("halt_rst_state", state, 0);

        // Saturation at 15, then clear beats a simultaneous bubble
        cmd_run = 1'b1;
        step_clk();
        cmd_run = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            jumped = 1'b1;
            bubble = (c <= 3);
            step_clk();
        end
        jumped = 1'b0; bubble = 1'b0;
        #1;
        check("sat_cnt_cycle", cnt_cycle, 15);
        check("sat_cnt_jump", cnt_jump, 15);
        check("sat_cnt_bubble", cnt_bubble, 3);
        check("sat_cnt_branch", cnt_branch, 0);
        cmd_clr_cnt = 1'b1; bubble = 1'b1; branched = 1'b1;
        step_clk();
        cmd_clr_cnt = 1'b0; bubble = 1'b0; cmd_pause = 1'b1;
        #1;
        check("clr_cnt_bubble", cnt_bubble, 0);
        check("clr_cnt_cycle", cnt_cycle, 0);
        check("clr_cnt_branch", cnt_branch, 0);
        step_clk();
        cmd_pause = 1'b0; branched = 1'b0;
        #1;
        check("post_clr_cnt_cycle", cnt_cycle, 1);
        check("post_clr_cnt_branch", cnt_branch, 1);
        check("post_clr_state", state, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/exec_step_controller.md
Name: exec_step_controller

Overview:
- Run-control sequencer for the pipelined CPU core; it owns the core's global `en` input.
- Supports free-run, single-cycle step, pause, PC breakpoint and terminal halt.
- Counts enabled cycles, taken jumps, taken branches and bubbles for performance display.
- Sits between board buttons/debug logic and the CPU top; consumes the core's pc_dbg, halted, jumped, branched and bubble outputs.

Parameters:
- CNT_BIT, 32, width of each statistics counter.
- PC_BIT, 32, width of pc_dbg and bp_addr.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cmd_run  in  1  single-cycle pulse: start/resume free-run.
- cmd_step  in  1  single-cycle pulse: execute exactly one enabled cycle.
- cmd_pause  in  1  single-cycle pulse: stop free-run.
- cmd_clr_cnt  in  1  single-cycle pulse: zero all counters.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  PC_BIT  breakpoint byte address.
- pc_dbg  in  PC_BIT  core current fetch PC (byte address).
- halted  in  1  core halt indication (syscall reached WB); held while core disabled.
- jumped  in  1  core: jump taken this cycle.
- branched  in  1  core: branch taken this cycle.
- bubble  in  1  core: load-use bubble inserted this cycle.
- en  out  1  core enable.
- state  out  2  0=IDLE 1=RUN 2=STEP 3=HALT.
- cnt_cycle  out  CNT_BIT  enabled-cycle count.
- cnt_jump  out  CNT_BIT  taken-jump count.
- cnt_branch  out  CNT_BIT  taken-branch count.
- cnt_bubble  out  CNT_BIT  bubble count.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous, active-low on rst_n.
- Reset values: state=IDLE, en=0, all counters=0, bp_armed=1.
- en is a combinational decode:
  - en = (state==RUN && !bp_hit && !halted) || (state==STEP && !halted).
  - bp_hit = bp_en && bp_armed && (pc_dbg==bp_addr).
- IDLE:
  - cmd_run -> RUN, clearing bp_armed (resume skips a breakpoint at the current PC).
  - Otherwise cmd_step -> STEP; cmd_run has priority if both are asserted.
  - cmd_pause is ignored.
- RUN, evaluated in priority order:
  - halted -> HALT.
  - cmd_pause -> IDLE; en stays 1 in the pulse cycle.
  - bp_hit -> IDLE; en is 0 in the same cycle, so the instruction at bp_addr is not fetched-past.
  - Otherwise stay in RUN.
- STEP:
  - Lasts exactly one cycle with en=1 (unless halted), then -> IDLE; halted -> HALT instead.
  - Breakpoints are ignored in STEP. Commands arriving during STEP are dropped.
- HALT: en=0; all cmd_* except cmd_clr_cnt are ignored; exit only via rst_n.
- bp_armed:
  - Cleared on the RUN-entry cycle and by each STEP.
  - Set again on any cycle where pc_dbg != bp_addr.
  - Changing bp_addr while armed takes effect immediately.
- Counters:
  - Each cycle with en=1: cnt_cycle+1; cnt_jump+1 if jumped; cnt_branch+1 if branched; cnt_bubble+1 if bubble.
  - Inputs are sampled only while en=1.
  - Counters saturate at all-ones; no wrap.
  - cmd_clr_cnt zeroes all counters next cycle; clear beats a simultaneous increment.
- Reset mid-RUN or mid-STEP: the next cycle is IDLE with en=0 and counters zeroed regardless of other inputs.
- Outputs change only on the clk edge except en, which also follows halted/pc_dbg combinationally.

Test Plan:
- Reset → IDLE: hold rst_n=0 for 2 cycles with cmd_run=1 → state=0, en=0, all counters 0; after release with no command, en stays 0.
- Run then pause: cmd_run pulse at cycle 0; cmd_pause pulse at cycle 10 → en=1 for cycles 1..10, state=0 from cycle 11; cnt_cycle=10.
- Single step: 3 cmd_step pulses spaced 4 cycles apart → en high for exactly 1 cycle after each; cnt_cycle=3; a cmd_step during STEP adds nothing.
- Breakpoint and resume:
  - bp_en=1, bp_addr=0x20, pc_dbg advancing by 4 from 0 → en drops in the cycle pc_dbg=0x20; state=IDLE.
  - cmd_run → en=1 continuously past 0x20 with no re-stop.
  - pc_dbg returns to 0x20 later → stops again.
- Halt: halted asserted at cycle 7 of RUN → en=0 in cycle 7, state=3; cmd_run/cmd_step ignored; only rst_n=0 returns state to 0.
- Counter events and saturation:
  - With CNT_BIT=4, run 20 enabled cycles with jumped=1 every cycle → cnt_cycle=cnt_jump=15.
  - cmd_clr_cnt with simultaneous bubble=1 → cnt_bubble=0 next cycle.
